// File: rtl/button_pkg.sv
// Shared types and 50 MHz timing defaults for the push-button action unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package button_pkg;

    // Per-channel debounce / repeat state
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DEB_PRESS   = 3'd1,
        HOLD        = 3'd2,
        REPEAT      = 3'd3,
        DEB_RELEASE = 3'd4
    } btn_state_e;

    // Default timing at 50 MHz: 10 ms debounce, 300 ms repeat delay, 100 ms repeat period
    localparam int DEF_NUM_BTN         = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REPEAT_DELAY    = 15000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;

    // Counter width: enough bits to reach the largest cycle count minus one
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button: debounce FSM plus shared counter, emits press/repeat strobes and the debounced level.
// Latency: press pulse DEBOUNCE_CYCLES-1 edges after first high sample; outputs registered.
// Backpressure: none; pulses are fire-and-forget strobes.
// Hold-to-repeat is compiled in only when BUTTON_AUTO_REPEAT_EN is defined.
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic pulse,
    output logic held
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             held_q, held_d;

    // Next-state, counter and output decode; outputs are computed here and registered below
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        held_d  = held_q;
        case (state_q)
            IDLE: begin
                held_d = 1'b0;
                if (btn_in) begin
                    state_d = DEB_PRESS;
                    cnt_d   = CNT_W'(1);
                end
            end
            DEB_PRESS: begin
                if (!btn_in) begin
                    // Bounce: drop back without ever announcing the press
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                    held_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!btn_in) begin
                    state_d = DEB_RELEASE;
                    cnt_d   = CNT_W'(1);
`ifdef BUTTON_AUTO_REPEAT_EN
                end else if (cnt_q == DLY_LAST) begin
                    state_d = REPEAT;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                end else begin
                    // Without auto-repeat the counter idles until release
                    cnt_d = '0;
                end
`endif
            end
`ifdef BUTTON_AUTO_REPEAT_EN
            REPEAT: begin
                if (!btn_in) begin
                    state_d = DEB_RELEASE;
                    cnt_d   = CNT_W'(1);
                end else if (cnt_q == PER_LAST) begin
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            DEB_RELEASE: begin
                held_d = 1'b1;
                if (btn_in) begin
                    // Release glitch: back to HOLD, repeat delay starts over, no pulse
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    held_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                held_d  = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            held_q  <= held_d;
        end
    end

    assign pulse = pulse_q;
    assign held  = held_q;

endmodule

// File: rtl/button_action_unit.sv
// Debounces NUM_BTN synchronized button levels into single-cycle action pulses (optional hold-to-repeat).
// Latency: press pulse DEBOUNCE_CYCLES-1 edges after first high sample; all outputs registered.
// Backpressure: none; channels are independent and may pulse in the same cycle.
// Hold-to-repeat is enabled by defining BUTTON_AUTO_REPEAT_EN.
module button_action_unit
    import button_pkg::*;
#(
    parameter int NUM_BTN         = DEF_NUM_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] pulse,
    output logic [NUM_BTN-1:0] held
);

    // One independent debounce/repeat channel per button bit
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .btn_in (btn_in[i]),
            .pulse  (pulse[i]),
            .held   (held[i])
        );
    end

endmodule

// File: tb/tb_button_action_unit.sv
// Directed, table-driven bench for button_action_unit with DEBOUNCE=4, DELAY=10, PERIOD=5.
// Each row: input applied before an edge, outputs compared 1 time unit after that edge.
// Expectations track BUTTON_AUTO_REPEAT_EN so the same bench covers both builds.
module tb_button_action_unit;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_in;
    logic [3:0] pulse;
    logic [3:0] held;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] btn;
        logic [3:0] pulse;
        logic [3:0] held;
    } vec_t;

    vec_t vecs[$];

    button_action_unit #(
        .NUM_BTN         (4),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_in (btn_in),
        .pulse  (pulse),
        .held   (held)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic [3:0] b, input logic [3:0] p, input logic [3:0] h);
        vec_t v;
        v.btn   = b;
        v.pulse = p;
        v.held  = h;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [3:0] ap, input logic [3:0] ah,
                         input logic [3:0] ep, input logic [3:0] eh);
        checks++;
        if (ap !== ep || ah !== eh) begin
            errors++;
            $display("FAIL %s: got pulse=%b held=%b, expected pulse=%b held=%b", name, ap, ah, ep, eh);
        end
    endtask

    task automatic step(input logic [3:0] b, input logic [3:0] ep, input logic [3:0] eh,
                        input string name);
        btn_in = b;
        @(posedge clk);
        #1;
        check(name, pulse, held, ep, eh);
    endtask

    initial begin
        logic p;

        // ---- Vector table ----
        // Clean press on ch0 held 30 cycles: rows 0..29 are edges 0..29
        for (int i = 0; i < 30; i++) begin
            p = (i == 3) || (AR && (i == 13 || i == 18 || i == 23 || i == 28));
            add(4'b0001, {3'b000, p}, (i >= 3) ? 4'b0001 : 4'b0000);
        end
        // Release ch0: held falls 3 edges after the first low sample, never a pulse
        add(4'b0000, 4'b0000, 4'b0001);
        add(4'b0000, 4'b0000, 4'b0001);
        add(4'b0000, 4'b0000, 4'b0001);
        add(4'b0000, 4'b0000, 4'b0000);
        // Bounce on ch1: 1,1,0,1,1,0 -> nothing
        add(4'b0010, 4'b0000, 4'b0000);
        add(4'b0010, 4'b0000, 4'b0000);
        add(4'b0000, 4'b0000, 4'b0000);
        add(4'b0010, 4'b0000, 4'b0000);
        add(4'b0010, 4'b0000, 4'b0000);
        add(4'b0000, 4'b0000, 4'b0000);
        // Stable 4-cycle high on ch1 -> exactly one pulse
        add(4'b0010, 4'b0000, 4'b0000);
        add(4'b0010, 4'b0000, 4'b0000);
        add(4'b0010, 4'b0000, 4'b0000);
        add(4'b0010, 4'b0010, 4'b0010);
        add(4'b0000, 4'b0000, 4'b0010);
        add(4'b0000, 4'b0000, 4'b0010);
        add(4'b0000, 4'b0000, 4'b0010);
        add(4'b0000, 4'b0000, 4'b0000);
        // ch2 and ch3 pressed together -> simultaneous pulses
        add(4'b1100, 4'b0000, 4'b0000);
        add(4'b1100, 4'b0000, 4'b0000);
        add(4'b1100, 4'b0000, 4'b0000);
        add(4'b1100, 4'b1100, 4'b1100);
        add(4'b0000, 4'b0000, 4'b1100);
        add(4'b0000, 4'b0000, 4'b1100);
        add(4'b0000, 4'b0000, 4'b1100);
        add(4'b0000, 4'b0000, 4'b0000);

        // ---- Reset state ----
        reset  = 1'b0;
        btn_in = 4'b0000;
        @(posedge clk);
        #1;
        check("reset_state", pulse, held, 4'b0000, 4'b0000);
        reset = 1'b1;

        // ---- Apply table ----
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].btn, vecs[i].pulse, vecs[i].held, $sformatf("vec%0d", i));
        end

        // ---- Release glitch during HOLD on ch0 ----
        step(4'b0001, 4'b0000, 4'b0000, "glitch_deb");
        step(4'b0001, 4'b0000, 4'b0000, "glitch_deb");
        step(4'b0001, 4'b0000, 4'b0000, "glitch_deb");
        step(4'b0001, 4'b0001, 4'b0001, "glitch_press");
        for (int k = 0; k < 3; k++) step(4'b0001, 4'b0000, 4'b0001, "glitch_hold");
        step(4'b0000, 4'b0000, 4'b0001, "glitch_low");
        step(4'b0000, 4'b0000, 4'b0001, "glitch_low");
        step(4'b0001, 4'b0000, 4'b0001, "glitch_return");
        // Repeat delay measured from the return, not from the original press
        for (int k = 1; k < 10; k++) step(4'b0001, 4'b0000, 4'b0001, $sformatf("glitch_wait%0d", k));
        step(4'b0001, AR ? 4'b0001 : 4'b0000, 4'b0001, "glitch_repeat");
        step(4'b0000, 4'b0000, 4'b0001, "glitch_rel");
        step(4'b0000, 4'b0000, 4'b0001, "glitch_rel");
        step(4'b0000, 4'b0000, 4'b0001, "glitch_rel");
        step(4'b0000, 4'b0000, 4'b0000, "glitch_rel_done");

        // ---- Reset while ch0 is held in the repeat phase ----
        step(4'b0001, 4'b0000, 4'b0000, "rst_deb");
        step(4'b0001, 4'b0000, 4'b0000, "rst_deb");
        step(4'b0001, 4'b0000, 4'b0000, "rst_deb");
        step(4'b0001, 4'b0001, 4'b0001, "rst_press");
        for (int k = 1; k <= 12; k++)
            step(4'b0001, (AR && k == 10) ? 4'b0001 : 4'b0000, 4'b0001, $sformatf("rst_hold%0d", k));
        reset = 1'b0;
        step(4'b0001, 4'b0000, 4'b0000, "rst_mid");
        reset = 1'b1;
        step(4'b0001, 4'b0000, 4'b0000, "rst_redeb");
        step(4'b0001, 4'b0000, 4'b0000, "rst_redeb");
        step(4'b0001, 4'b0000, 4'b0000, "rst_redeb");
        step(4'b0001, 4'b0001, 4'b0001, "rst_repress");
        step(4'b0001, 4'b0000, 4'b0001, "rst_pulse_drop");
        step(4'b0000, 4'b0000, 4'b0001, "rst_rel");
        step(4'b0000, 4'b0000, 4'b0001, "rst_rel");
        step(4'b0000, 4'b0000, 4'b0001, "rst_rel");
        step(4'b0000, 4'b0000, 4'b0000, "rst_rel_done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_action_unit.md
# button_action_unit

Debounces the synchronized push-button levels and converts each into single-cycle action pulses with optional hold-to-repeat. Sits between the button synchronizer and the `tetris` game core: its pulse outputs drive `move_right`, `move_left` and any future per-button move/rotate inputs. It replaces raw edge detection, which reacts to contact bounce and cannot auto-repeat.

## Interface
- `NUM_BTN`, 4: number of independent button channels.
- `DEBOUNCE_CYCLES`, 500000: consecutive equal samples required to accept a level change (10 ms at 50 MHz). Must be ≥ 2.
- `REPEAT_DELAY`, 15000000: cycles from the press pulse to the first repeat pulse (300 ms). Must be ≥ 2.
- `REPEAT_PERIOD`, 5000000: cycles between subsequent repeat pulses (100 ms). Must be ≥ 2.

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-low; sampled 0 at a rising edge resets the block.
- `btn_in` in NUM_BTN: button levels, already synchronized to `clk`; 1 = pressed.
- `pulse` out NUM_BTN: one-cycle action strobe per button.
- `held` out NUM_BTN: debounced button level.

## Operation
- Each channel is independent; no arbitration between channels, so several `pulse` bits may be high in the same cycle.
- Per-channel state machine, one counter `cnt`:
  - IDLE: `held`=0. `btn_in`=1 → DEB_PRESS, `cnt`=1.
  - DEB_PRESS: `btn_in`=0 → IDLE (bounce rejected, no pulse). Else if `cnt`==DEBOUNCE_CYCLES−1 → HOLD, `cnt`=0, `pulse`=1, `held`=1. Else `cnt`++.
  - HOLD: `btn_in`=0 → DEB_RELEASE, `cnt`=1. Else if `cnt`==REPEAT_DELAY−1 → REPEAT, `cnt`=0, `pulse`=1. Else `cnt`++.
  - REPEAT: `btn_in`=0 → DEB_RELEASE, `cnt`=1. Else if `cnt`==REPEAT_PERIOD−1 → `cnt`=0, `pulse`=1. Else `cnt`++.
  - DEB_RELEASE: `held` stays 1. `btn_in`=1 → HOLD, `cnt`=0, no pulse; a release glitch restarts the repeat delay. Else if `cnt`==DEBOUNCE_CYCLES−1 → IDLE, `held`=0. Else `cnt`++.
- `pulse` is never asserted on release.
- Counter width is `$clog2` of the largest of the three cycle parameters. Counting saturates only through the state transitions above and never wraps.

## Timing
- Reset: every channel enters IDLE, `cnt`=0, `pulse`=0, `held`=0 on the edge that samples `reset`=0.
- All outputs are registered; there is no combinational path from `btn_in` to outputs.
- Press latency: if `btn_in` is first sampled 1 at edge E and stays 1, `pulse` and `held` go high after edge E+DEBOUNCE_CYCLES−1. `pulse` drops after the next edge.
- First repeat: REPEAT_DELAY cycles after the press pulse. Subsequent repeats are every REPEAT_PERIOD cycles.
- Release latency: `held` falls DEBOUNCE_CYCLES−1 edges after the first low sample, provided the input stays low.
- Reset mid-hold: if the button is still pressed after reset deasserts, it is treated as a fresh press, with full debounce and then one pulse.

## Configuration
- `BUTTON_AUTO_REPEAT_EN` defined: REPEAT state and the HOLD→REPEAT transition are compiled in, as described above.
- Not defined: HOLD only waits for release and never emits `pulse`; the REPEAT state and the `REPEAT_*` comparison logic are absent. Parameters are still accepted but unused. The result is one pulse per debounced press.

## Structure
- Shared package `button_pkg`:
  - state enum (IDLE, DEB_PRESS, HOLD, REPEAT, DEB_RELEASE);
  - default timing constants for 50 MHz.
- Sub-module `button_channel`: one FSM plus counter per button. `button_action_unit` instantiates NUM_BTN copies in a generate loop and concatenates their outputs.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
- Clean press: `btn_in[0]` rises at edge 0 and holds → `pulse[0]` high only after edge 3, `held[0]` high from edge 3; other bits stay 0.
- Bounce: `btn_in[1]` toggles 1,1,0,1,1,0 → no pulse and `held[1]`=0. A subsequent stable 4-cycle high gives exactly one pulse.
- Auto-repeat (macro defined): hold `btn_in[0]` for 30 cycles → pulses after edges 3, 13, 18, 23, 28.
- Macro undefined: same stimulus → single pulse after edge 3 only.
- Release glitch: during HOLD drive 0 for 2 cycles, then 1 → `held` stays 1, no pulse, and the repeat delay restarts from the return to 1.
- Reset mid-repeat: assert `reset`=0 for 1 cycle while held → outputs 0 on the next edge. The button still held then gives a pulse 4 cycles after reset release.
